// File: rtl/rollo_support_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rollo_support_sampler
// Function : Loads the r support basis elements into the GF(2^m) support
//            register file, then issues n random-combination commands driven
//            by a 32-bit Galois LFSR and streams the resulting error
//            coefficients downstream with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rollo_support_sampler #(
   parameter int N = 83,   // coefficients per job
   parameter int M = 67,   // field element width
   parameter int R = 7     // support dimension / register-file depth
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  start,
   input  logic [31:0]           seed,
   input  logic                  basis_valid,
   input  logic [M-1:0]          basis_data,
   output logic                  basis_ready,
   output logic                  rf_rw,
   output logic [R:0]            rf_ctrl_w,
   output logic [$clog2(R)-1:0]  rf_addr,
   output logic [M-1:0]          rf_data_in,
   input  logic [M-1:0]          rf_data_out,
   output logic                  coef_valid,
   output logic [M-1:0]          coef_data,
   output logic [$clog2(N)-1:0]  coef_idx,
   input  logic                  coef_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int AW = $clog2(R);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N + 1);   // issue counter must reach N

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_load  = 2'd1;
   localparam logic [1:0] c_gen   = 2'd2;
   localparam logic [1:0] c_flush = 2'd3;

   localparam logic [AW-1:0] c_last_load  = AW'(R - 1);
   localparam logic [CW-1:0] c_n          = CW'(N);
   localparam logic [CW-1:0] c_last_issue = CW'(N - 1);
   localparam logic [IW-1:0] c_last_idx   = IW'(N - 1);
   localparam logic [31:0]   c_lfsr_taps  = 32'h8020_0003;

   logic [1:0]    r_state;
   logic [1:0]    w_next_state;
   logic [31:0]   r_lfsr;
   logic [AW-1:0] r_load_cnt;
   logic [CW-1:0] r_issue_cnt;
   logic [IW-1:0] r_cap_cnt;
   logic          r_pending;
   logic          r_coef_valid;
   logic [M-1:0]  r_coef_data;
   logic [IW-1:0] r_coef_idx;

   logic          w_load_acc;
   logic          w_issue;
   logic          w_accept;
   logic          w_last_accept;
   logic [31:0]   w_lfsr_step;

   // Handshake qualifiers shared by the FSM, datapath and outputs.
   assign w_load_acc    = (r_state == c_load) && basis_valid;
   assign w_issue       = (r_state == c_gen) && (r_issue_cnt < c_n) && !r_pending
                          && (!r_coef_valid || coef_ready);
   assign w_accept      = r_coef_valid && coef_ready;
   assign w_last_accept = (r_state == c_flush) && w_accept && (r_coef_idx == c_last_idx);
   assign w_lfsr_step   = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : 32'h0);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_b) r_state <= c_idle;
      else        r_state <= w_next_state;
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_idle:  if (start) w_next_state = c_load;
         c_load:  if (w_load_acc && (r_load_cnt == c_last_load)) w_next_state = c_gen;
         c_gen:   if (w_issue && (r_issue_cnt == c_last_issue)) w_next_state = c_flush;
         c_flush: if (w_last_accept) w_next_state = c_idle;
         default: w_next_state = c_idle;
      endcase
   end

   // Register-file strobes and status outputs, combinational from state and handshake.
   always_comb begin
      basis_ready = 1'b0;
      rf_rw       = 1'b0;
      rf_ctrl_w   = '0;
      rf_addr     = '0;
      rf_data_in  = '0;
      case (r_state)
         c_load: begin
            basis_ready = 1'b1;
            rf_rw       = basis_valid;
            rf_addr     = r_load_cnt;
            rf_data_in  = basis_data;
         end
         c_gen: begin
            // MSB of the random field selects entry 0.
            if (w_issue) rf_ctrl_w = {1'b1, r_lfsr[R-1:0]};
         end
         default: ;
      endcase
      busy = (r_state != c_idle);
      done = w_last_accept;
   end

   // Job datapath: counters, LFSR, command pending flag and output slot.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_lfsr       <= 32'd1;
         r_load_cnt   <= '0;
         r_issue_cnt  <= '0;
         r_cap_cnt    <= '0;
         r_pending    <= 1'b0;
         r_coef_valid <= 1'b0;
         r_coef_data  <= '0;
         r_coef_idx   <= '0;
      end else begin
         if ((r_state == c_idle) && start) begin
            r_lfsr     <= (seed == 32'd0) ? 32'd1 : seed;
            r_load_cnt <= '0;
            r_cap_cnt  <= '0;
         end
         if (w_load_acc) begin
            r_load_cnt <= r_load_cnt + 1'b1;
            if (r_load_cnt == c_last_load) r_issue_cnt <= '0;
         end
         if (w_issue) begin
            r_pending   <= 1'b1;
            r_lfsr      <= w_lfsr_step;
            r_issue_cnt <= r_issue_cnt + 1'b1;
         end
         // The issue rule guarantees the slot is free when the capture lands.
         if (r_pending) begin
            r_coef_data  <= rf_data_out;
            r_coef_idx   <= r_cap_cnt;
            r_coef_valid <= 1'b1;
            r_pending    <= 1'b0;
            r_cap_cnt    <= r_cap_cnt + 1'b1;
         end else if (w_accept) begin
            r_coef_valid <= 1'b0;
         end
      end
   end

   assign coef_valid = r_coef_valid;
   assign coef_data  = r_coef_data;
   assign coef_idx   = r_coef_idx;

endmodule
`default_nettype wire

// File: tb/tb_rollo_support_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rollo_support_sampler
// Function : Self-checking bench with a behavioural register file and a
//            coefficient reference model derived from the LFSR rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rollo_support_sampler;

   localparam int N = 83;
   localparam int M = 67;
   localparam int R = 7;

   logic                  clk = 1'b0;
   logic                  rst_b;
   logic                  start;
   logic [31:0]           seed;
   logic                  basis_valid;
   logic [M-1:0]          basis_data;
   logic                  basis_ready;
   logic                  rf_rw;
   logic [R:0]            rf_ctrl_w;
   logic [$clog2(R)-1:0]  rf_addr;
   logic [M-1:0]          rf_data_in;
   logic [M-1:0]          rf_data_out;
   logic                  coef_valid;
   logic [M-1:0]          coef_data;
   logic [$clog2(N)-1:0]  coef_idx;
   logic                  coef_ready;
   logic                  busy;
   logic                  done;

   int tests = 0;
   int fails = 0;

   logic [M-1:0] rf_mem [8];
   logic [M-1:0] basis_q [R];
   logic [R-1:0] exp_field [N];
   logic [M-1:0] exp_coef [N];

   always #5 clk = ~clk;

   rollo_support_sampler #(.N(N), .M(M), .R(R)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .seed(seed),
      .basis_valid(basis_valid), .basis_data(basis_data), .basis_ready(basis_ready),
      .rf_rw(rf_rw), .rf_ctrl_w(rf_ctrl_w), .rf_addr(rf_addr), .rf_data_in(rf_data_in),
      .rf_data_out(rf_data_out), .coef_valid(coef_valid), .coef_data(coef_data),
      .coef_idx(coef_idx), .coef_ready(coef_ready), .busy(busy), .done(done)
   );

   // Behavioural support register file: writes, and XOR of selected entries
   // returned with one cycle of latency.
   function automatic logic [M-1:0] rf_select(input logic [R-1:0] sel);
      logic [M-1:0] acc = '0;
      for (int i = 0; i < R; i++) if (sel[R-1-i]) acc = acc ^ rf_mem[i];
      return acc;
   endfunction

   always @(posedge clk) begin
      if (rf_rw) rf_mem[rf_addr] <= rf_data_in;
      if (rf_ctrl_w[R]) rf_data_out <= rf_select(rf_ctrl_w[R-1:0]);
   end

   // Reference model: coefficient k is the XOR of the basis elements chosen
   // by the k-th LFSR state's low r bits (MSB of the field -> element 0).
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [M-1:0] combine(input logic [R-1:0] field);
      logic [M-1:0] acc = '0;
      for (int i = 0; i < R; i++) if (field[R-1-i]) acc = acc ^ basis_q[i];
      return acc;
   endfunction

   task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_basis(input bit unit);
      for (int i = 0; i < R; i++)
         basis_q[i] = unit ? (M'(1) << i) : M'({$urandom, $urandom, $urandom});
   endtask

   // mode 0: always ready, 1: 10-cycle stall after first valid, 2: random ready
   task automatic run_job(input logic [31:0] s, input int mode, input bit known,
                          input bit poke_start, input int abort_at);
      logic [31:0]          st;
      int                   i, cyc, issues, accepts, stall_cnt;
      bit                   seen_valid, prev_stall;
      logic [M-1:0]         prev_data;
      logic [$clog2(N)-1:0] prev_idx;

      st = (s == 32'd0) ? 32'd1 : s;
      for (int k = 0; k < N; k++) begin
         exp_field[k] = st[R-1:0];
         exp_coef[k]  = combine(st[R-1:0]);
         st = lfsr_next(st);
      end

      @(negedge clk);
      start = 1'b1; seed = s;
      #1 check("idle_busy", M'(busy), M'(0));
      @(negedge clk);
      start = 1'b0;
      #1 check("load_busy", M'(busy), M'(1));
      check("load_basis_ready", M'(basis_ready), M'(1));

      i = 0; cyc = 0;
      while (i < R && cyc < 200) begin
         if (mode == 2 && $urandom_range(0, 2) == 0) begin
            basis_valid = 1'b0;
            #1 check("load_gap_rw", M'(rf_rw), M'(0));
         end else begin
            basis_valid = 1'b1; basis_data = basis_q[i];
            #1 check("load_rw", M'(rf_rw), M'(1));
            check("load_addr", M'(rf_addr), M'(i));
            check("load_data", rf_data_in, basis_q[i]);
            check("load_ctrl", M'(rf_ctrl_w), M'(0));
            i++;
         end
         cyc++;
         @(negedge clk);
      end
      if (i < R) check("load_timeout", M'(i), M'(R));
      basis_valid = 1'b0;
      #1 check("load_ready_drop", M'(basis_ready), M'(0));

      issues = 0; accepts = 0; stall_cnt = 0; cyc = 0;
      seen_valid = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
      while (accepts < N && cyc < 5000) begin
         seen_valid = seen_valid | coef_valid;
         if (mode == 0) coef_ready = 1'b1;
         else if (mode == 1) begin
            if (seen_valid && stall_cnt < 10) begin coef_ready = 1'b0; stall_cnt++; end
            else coef_ready = 1'b1;
         end else coef_ready = 1'($urandom_range(0, 1));
         if (poke_start) begin start = 1'($urandom_range(0, 1)); seed = $urandom; end
         #1;
         check("gen_busy", M'(busy), M'(1));
         if (prev_stall) begin
            check("bp_valid_hold", M'(coef_valid), M'(1));
            check("bp_data_hold", coef_data, prev_data);
            check("bp_idx_hold", M'(coef_idx), M'(prev_idx));
         end
         if (coef_valid && !coef_ready) check("bp_no_issue", M'(rf_ctrl_w[R]), M'(0));
         if (rf_ctrl_w[R]) begin
            if (issues < N) check("cmd_field", M'(rf_ctrl_w[R-1:0]), M'(exp_field[issues]));
            else check("cmd_overrun", M'(issues), M'(N - 1));
            check("cmd_rw", M'(rf_rw), M'(0));
            check("cmd_addr", M'(rf_addr), M'(0));
            if (known && issues == 0) check("known_cmd0", M'(rf_ctrl_w), M'(8'b1000_0001));
            if (known && issues == 1) check("known_cmd1", M'(rf_ctrl_w), M'(8'b1000_0011));
            issues++;
         end
         if (coef_valid && coef_ready) begin
            check("coef_idx", M'(coef_idx), M'(accepts));
            check("coef_data", coef_data, exp_coef[accepts]);
            check("done_pulse", M'(done), M'(accepts == N - 1));
            if (known && accepts == 0) check("known_coef0", coef_data, M'(67'h40));
            if (known && accepts == 1) check("known_coef1", coef_data, M'(67'h60));
            accepts++;
         end else begin
            check("done_idle", M'(done), M'(0));
         end
         prev_stall = coef_valid && !coef_ready;
         prev_data  = coef_data;
         prev_idx   = coef_idx;

         if (abort_at >= 0 && issues >= abort_at) begin
            rst_b = 1'b0;
            @(negedge clk);
            rst_b = 1'b1; start = 1'b0; basis_valid = 1'b1; coef_ready = 1'b1;
            #1 check("abort_valid", M'(coef_valid), M'(0));
            check("abort_data", coef_data, M'(0));
            check("abort_idx", M'(coef_idx), M'(0));
            check("abort_done", M'(done), M'(0));
            for (int c = 0; c < 20; c++) begin
               check("abort_busy", M'(busy), M'(0));
               check("abort_rw", M'(rf_rw), M'(0));
               check("abort_ctrl", M'(rf_ctrl_w), M'(0));
               check("abort_basis_ready", M'(basis_ready), M'(0));
               @(negedge clk);
               #1;
            end
            basis_valid = 1'b0;
            return;
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      if (accepts < N) check("gen_timeout", M'(accepts), M'(N));
      #1 check("end_busy", M'(busy), M'(0));
      check("end_done", M'(done), M'(0));
      check("end_issue_count", M'(issues), M'(N));
   endtask

   initial begin
      rst_b = 1'b0; start = 1'b1; seed = 32'h1234_5678;
      basis_valid = 1'b0; basis_data = '0; coef_ready = 1'b0;

      // Reset held for two cycles with start asserted.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1 check("rst_busy", M'(busy), M'(0));
         check("rst_valid", M'(coef_valid), M'(0));
         check("rst_rw", M'(rf_rw), M'(0));
         check("rst_ctrl", M'(rf_ctrl_w), M'(0));
         check("rst_data", coef_data, M'(0));
         check("rst_idx", M'(coef_idx), M'(0));
         check("rst_done", M'(done), M'(0));
      end
      rst_b = 1'b1; start = 1'b0;
      @(negedge clk);
      #1 check("post_rst_idle", M'(busy), M'(0));

      set_basis(1'b1);
      run_job(32'd1, 0, 1'b1, 1'b0, -1);      // known sequence, full run
      set_basis(1'b0);
      run_job($urandom, 1, 1'b0, 1'b0, -1);   // backpressure
      set_basis(1'b1);
      run_job(32'd0, 0, 1'b1, 1'b0, -1);      // seed 0 acts as seed 1
      set_basis(1'b0);
      run_job($urandom, 2, 1'b0, 1'b1, -1);   // random ready, start poked in GEN
      set_basis(1'b0);
      run_job($urandom, 2, 1'b0, 1'b0, 5);    // reset mid-GEN
      set_basis(1'b0);
      run_job($urandom, 0, 1'b0, 1'b0, -1);   // recovery after abort

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
